// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared types and constants for the Simon game datapath
//
// color_t is the 2-bit color code used by the generator, this engine and the
// display stage. state_t enumerates the sequence-engine FSM states.
package simon_pkg;

    typedef logic [1:0] color_t;

    localparam color_t RED    = 2'd0;
    localparam color_t GREEN  = 2'd1;
    localparam color_t BLUE   = 2'd2;
    localparam color_t YELLOW = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SHOW,
        GAP,
        INPUT,
        WIN,
        LOSE
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/simon_sequence_if.sv
// rtl/simon_sequence_if.sv - player, generator and display signals of the sequence engine
//
// master : game top level / testbench (drives rand_num, start, button presses)
// slave  : simon_sequence (drives lamp, status and level outputs)
interface simon_sequence_if #(
    parameter int MAX_LEN = 32
) ();
    import simon_pkg::*;

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    color_t             rand_num;
    logic               start;
    logic               btn_valid;
    color_t             btn_color;
    logic               led_on;
    color_t             led_color;
    logic               awaiting_input;
    logic [LEN_W-1:0]   level;
    logic               round_pass;
    logic               game_over;
    logic               game_won;

    modport master (
        output rand_num, start, btn_valid, btn_color,
        input  led_on, led_color, awaiting_input, level, round_pass, game_over, game_won
    );

    modport slave (
        input  rand_num, start, btn_valid, btn_color,
        output led_on, led_color, awaiting_input, level, round_pass, game_over, game_won
    );
endinterface

// File: rtl/simon_seq_mem.sv
// rtl/simon_seq_mem.sv - pattern storage, one synchronous write port and two asynchronous read ports
//
// CLK              : clock
// we/waddr/wdata   : write one color at the rising edge
// raddr_a/rdata_a  : playback read port
// raddr_b/rdata_b  : input-check read port
// Contents are deliberately not reset; only entries below the current level are read.
module simon_seq_mem
    import simon_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic            CLK,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  color_t          wdata,
    input  logic [AW-1:0]   raddr_a,
    output color_t          rdata_a,
    input  logic [AW-1:0]   raddr_b,
    output color_t          rdata_b
);
    color_t mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/simon_sequence.sv
// rtl/simon_sequence.sv - Simon game-sequence engine: grows, plays back and checks the color pattern
//
// CLK  : clock, all state changes on the rising edge
// RST  : synchronous active-high reset (overrides start)
// bus  : simon_sequence_if.slave
//        in  rand_num, start, btn_valid, btn_color
//        out led_on, led_color, awaiting_input, level, round_pass, game_over, game_won
module simon_sequence #(
    parameter int MAX_LEN    = 32,
    parameter int ON_CYCLES  = 50_000_000,
    parameter int OFF_CYCLES = 25_000_000
) (
    input  logic            CLK,
    input  logic            RST,
    simon_sequence_if.slave bus
);
    import simon_pkg::*;

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int CNT_W = $clog2(max_int(ON_CYCLES, OFF_CYCLES) + 1);

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

    state_t             state;
    logic [IDX_W-1:0]   play_idx;
    logic [IDX_W-1:0]   chk_idx;
    logic [CNT_W-1:0]   cnt;

    color_t             play_rd;
    color_t             chk_rd;
    logic [IDX_W-1:0]   play_raddr;
    logic               hit;
    logic               last_entry;
    logic               at_max;
    logic               grow;
    logic               mem_we;
    logic [IDX_W-1:0]   waddr;

    // led_color is registered, so the playback port looks one entry ahead
    // while in GAP; in INPUT it points at entry 0 for the next round's replay.
    assign play_raddr = (state == GAP) ? play_idx + IDX_W'(1) : '0;

    assign hit        = bus.btn_valid && (bus.btn_color == chk_rd);
    assign last_entry = (LEN_W'(chk_idx) == bus.level - LEN_W'(1));
    assign at_max     = (bus.level == LEN_W'(MAX_LEN));
    assign grow       = (state == INPUT) && !bus.start && hit && last_entry && !at_max;

    // start always writes entry 0; a completed round appends at index level.
    assign mem_we = bus.start || grow;
    assign waddr  = bus.start ? '0 : bus.level[IDX_W-1:0];

    simon_seq_mem #(
        .DEPTH   (MAX_LEN),
        .AW      (IDX_W)
    ) u_mem (
        .CLK     (CLK),
        .we      (mem_we),
        .waddr   (waddr),
        .wdata   (bus.rand_num),
        .raddr_a (play_raddr),
        .rdata_a (play_rd),
        .raddr_b (chk_idx),
        .rdata_b (chk_rd)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state              <= IDLE;
            play_idx           <= '0;
            chk_idx            <= '0;
            cnt                <= '0;
            bus.led_on         <= 1'b0;
            bus.led_color      <= RED;
            bus.awaiting_input <= 1'b0;
            bus.level          <= '0;
            bus.round_pass     <= 1'b0;
            bus.game_over      <= 1'b0;
            bus.game_won       <= 1'b0;
        end else begin
            bus.round_pass <= 1'b0;
            if (bus.start) begin
                state              <= SHOW;
                play_idx           <= '0;
                chk_idx            <= '0;
                cnt                <= ON_LOAD;
                bus.level          <= LEN_W'(1);
                bus.led_on         <= 1'b1;
                bus.led_color      <= bus.rand_num;
                bus.awaiting_input <= 1'b0;
                bus.game_over      <= 1'b0;
                bus.game_won       <= 1'b0;
            end else begin
                case (state)
                    SHOW: begin
                        if (cnt == '0) begin
                            state         <= GAP;
                            cnt           <= OFF_LOAD;
                            bus.led_on    <= 1'b0;
                            bus.led_color <= RED;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    GAP: begin
                        if (cnt == '0) begin
                            if (LEN_W'(play_idx) == bus.level - LEN_W'(1)) begin
                                state              <= INPUT;
                                chk_idx            <= '0;
                                cnt                <= '0;
                                bus.awaiting_input <= 1'b1;
                            end else begin
                                state         <= SHOW;
                                play_idx      <= play_idx + IDX_W'(1);
                                cnt           <= ON_LOAD;
                                bus.led_on    <= 1'b1;
                                bus.led_color <= play_rd;
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    INPUT: begin
                        if (bus.btn_valid) begin
                            if (!hit) begin
                                state              <= LOSE;
                                bus.awaiting_input <= 1'b0;
                                bus.game_over      <= 1'b1;
                            end else if (!last_entry) begin
                                chk_idx <= chk_idx + IDX_W'(1);
                            end else if (at_max) begin
                                state              <= WIN;
                                bus.awaiting_input <= 1'b0;
                                bus.game_won       <= 1'b1;
                            end else begin
                                state              <= SHOW;
                                play_idx           <= '0;
                                cnt                <= ON_LOAD;
                                bus.level          <= bus.level + LEN_W'(1);
                                bus.round_pass     <= 1'b1;
                                bus.awaiting_input <= 1'b0;
                                bus.led_on         <= 1'b1;
                                bus.led_color      <= play_rd;
                            end
                        end
                    end
                    default: begin
                        // IDLE, WIN and LOSE hold until start
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_simon_sequence.sv
// tb/tb_simon_sequence.sv - self-checking bench for simon_sequence (MAX_LEN=3, ON=3, OFF=2)
module tb_simon_sequence;
    import simon_pkg::*;

    localparam int MAX_LEN = 3;
    localparam int ON_C    = 3;
    localparam int OFF_C   = 2;

    logic CLK = 1'b0;
    logic RST;

    simon_sequence_if #(.MAX_LEN(MAX_LEN)) bus ();

    simon_sequence #(
        .MAX_LEN    (MAX_LEN),
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    bit     start_edge = 1'b0;
    bit     prev_led = 1'b0;
    int     flash_len = 0;
    color_t cur_exp = RED;
    color_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    // Flash scoreboard: every lamp-on period (or restart while lit) pops one
    // expected color; each completed flash must last exactly ON_C cycles.
    always @(posedge CLK) begin
        cyc++;
        start_edge = bus.start && !RST;
    end

    always @(negedge CLK) begin
        if (RST) begin
            prev_led  = 1'b0;
            flash_len = 0;
        end else begin
            if (bus.led_on && (!prev_led || start_edge)) begin
                chk("flash_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
                flash_len = 1;
            end else if (bus.led_on) begin
                flash_len++;
            end
            if (bus.led_on) chk("flash_color", bus.led_color, cur_exp);
            if (!bus.led_on && prev_led) chk("flash_len", flash_len, ON_C);
            prev_led = bus.led_on;
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_led_on"}, bus.led_on, 0);
        chk({tag, "_led_color"}, bus.led_color, 0);
        chk({tag, "_level"}, bus.level, 0);
        chk({tag, "_awaiting"}, bus.awaiting_input, 0);
        chk({tag, "_round_pass"}, bus.round_pass, 0);
        chk({tag, "_game_over"}, bus.game_over, 0);
        chk({tag, "_game_won"}, bus.game_won, 0);
    endtask

    task automatic do_start(input color_t r);
        bus.start    = 1'b1;
        bus.rand_num = r;
        exp_q.push_back(r);
        step();
        bus.start = 1'b0;
    endtask

    task automatic press(input color_t c, input color_t r);
        bus.btn_valid = 1'b1;
        bus.btn_color = c;
        bus.rand_num  = r;
        step();
        bus.btn_valid = 1'b0;
    endtask

    // Waits for INPUT; optionally hammers wrong presses meanwhile, which must be ignored.
    task automatic wait_input(input string tag, input bit spam, input int exp_dc);
        int  t0  = cyc;
        bit  got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            bus.btn_valid = spam;
            bus.btn_color = RED;
            step();
            got = bus.awaiting_input;
        end
        bus.btn_valid = 1'b0;
        chk({tag, "_reached"}, got, 1);
        chk({tag, "_cycles"}, cyc - t0, exp_dc);
    endtask

    initial begin
        RST           = 1'b1;
        bus.start     = 1'b0;
        bus.btn_valid = 1'b0;
        bus.btn_color = RED;
        bus.rand_num  = BLUE;
        step();
        step();
        check_reset("reset");
        RST = 1'b0;
        step();

        // First flash: lit 3, dark 2, then INPUT with level 1
        do_start(BLUE);
        chk("s1_on0", bus.led_on, 1);
        chk("s1_color", bus.led_color, BLUE);
        chk("s1_level", bus.level, 1);
        step(); chk("s1_on1", bus.led_on, 1);
        step(); chk("s1_on2", bus.led_on, 1);
        step(); chk("s1_off0", bus.led_on, 0);
        chk("s1_await_early", bus.awaiting_input, 0);
        step(); chk("s1_off1", bus.led_on, 0);
        step(); chk("s1_await", bus.awaiting_input, 1);
        chk("s1_level_in", bus.level, 1);

        // Round 1: press 2 while generator shows 1
        exp_q.push_back(BLUE);
        exp_q.push_back(GREEN);
        press(BLUE, GREEN);
        chk("r1_pass", bus.round_pass, 1);
        chk("r1_level", bus.level, 2);
        chk("r1_led", bus.led_on, 1);
        chk("r1_await", bus.awaiting_input, 0);
        bus.btn_valid = 1'b1;
        bus.btn_color = RED;
        step();
        bus.btn_valid = 1'b0;
        chk("r1_pass_once", bus.round_pass, 0);
        chk("r1_ignore_show", bus.game_over, 0);
        wait_input("r1_play", 1'b1, 9);
        chk("r1_ignore_gap", bus.game_over, 0);

        // Round 2: 2,1 then append 3
        press(BLUE, RED);
        chk("r2_mid_pass", bus.round_pass, 0);
        chk("r2_mid_await", bus.awaiting_input, 1);
        exp_q.push_back(BLUE);
        exp_q.push_back(GREEN);
        exp_q.push_back(YELLOW);
        press(GREEN, YELLOW);
        chk("r2_pass", bus.round_pass, 1);
        chk("r2_level", bus.level, 3);
        wait_input("r2_play", 1'b0, 15);

        // Round 3: full pattern at MAX_LEN wins
        press(BLUE, RED);
        press(GREEN, RED);
        chk("r3_won_early", bus.game_won, 0);
        press(YELLOW, RED);
        chk("win_flag", bus.game_won, 1);
        chk("win_level", bus.level, 3);
        chk("win_led", bus.led_on, 0);
        chk("win_await", bus.awaiting_input, 0);
        chk("win_no_pass", bus.round_pass, 0);
        press(RED, RED);
        chk("win_hold", bus.game_won, 1);
        chk("win_hold_level", bus.level, 3);

        // New game, lose at level 2 with 2 then 0
        do_start(BLUE);
        chk("g2_won_clr", bus.game_won, 0);
        wait_input("g2_l1", 1'b0, 5);
        exp_q.push_back(BLUE);
        exp_q.push_back(GREEN);
        press(BLUE, GREEN);
        wait_input("g2_l2", 1'b0, 10);
        press(BLUE, RED);
        chk("lose_early", bus.game_over, 0);
        press(RED, RED);
        chk("lose_flag", bus.game_over, 1);
        chk("lose_level", bus.level, 2);
        chk("lose_await", bus.awaiting_input, 0);
        press(GREEN, RED);
        chk("lose_hold", bus.game_over, 1);
        chk("lose_hold_level", bus.level, 2);
        chk("lose_led", bus.led_on, 0);

        // Restart mid-SHOW of level 2
        do_start(BLUE);
        chk("g3_over_clr", bus.game_over, 0);
        wait_input("g3_l1", 1'b0, 5);
        exp_q.push_back(BLUE);
        exp_q.push_back(GREEN);
        press(BLUE, GREEN);
        step();
        chk("mid_show_lit", bus.led_on, 1);
        exp_q.delete();
        do_start(RED);
        chk("mid_level", bus.level, 1);
        chk("mid_led", bus.led_on, 1);
        chk("mid_color", bus.led_color, RED);
        wait_input("mid_play", 1'b0, 5);

        // start together with a (wrong) press in INPUT: restart wins
        bus.btn_valid = 1'b1;
        bus.btn_color = YELLOW;
        do_start(YELLOW);
        bus.btn_valid = 1'b0;
        chk("sb_over", bus.game_over, 0);
        chk("sb_level", bus.level, 1);
        chk("sb_color", bus.led_color, YELLOW);
        chk("sb_await", bus.awaiting_input, 0);
        wait_input("sb_play", 1'b0, 5);

        // RST together with start: reset values
        RST          = 1'b1;
        bus.start    = 1'b1;
        bus.rand_num = GREEN;
        step();
        check_reset("rst_start");
        RST       = 1'b0;
        bus.start = 1'b0;
        step();
        chk("idle_level", bus.level, 0);
        chk("idle_led", bus.led_on, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
